// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and FSM state type for the fetch front-end
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: {pc, instr} buffer between imem responses and decode; flush wins over push/pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [AW:0]     count,
  output logic            empty,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop_ok;
  assign empty = count == '0;
  assign pop_ok = pop && !empty;
  assign head_pc = pc_mem[rp];
  assign head_instr = instr_mem[rp];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop_ok) rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_ok};
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wp] <= pc_in;
      instr_mem[wp] <= instr_in;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, single-outstanding imem req/gnt/rvalid fetch, buffered hand-off to decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [XLEN-1:0] fetch_pc, req_pc, head_pc, head_instr;
  logic [AW:0] count, after_push;
  logic empty, rsp, bypass, push, pop, space, space_after;
  assign rsp = state == WAIT && imem_rvalid && !redirect;
`ifdef FETCH_BYPASS_EN
  assign bypass = rsp && empty;
`else
  assign bypass = 1'b0;
`endif
  assign push = rsp && !(bypass && instr_ready);
  assign pop = instr_ready && !empty && !redirect;
  // The in-flight response already owns a slot, so WAIT needs one entry of headroom.
  assign space = state == WAIT ? count < (AW+1)'(DEPTH - 1) : count < (AW+1)'(DEPTH);
  assign after_push = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign space_after = after_push < (AW+1)'(DEPTH);
  assign imem_req = state == REQ;
  assign imem_addr = fetch_pc;
  assign instr_valid = !empty || bypass;
  assign instr = bypass ? imem_rdata : !empty ? head_instr : NOP_INSTR;
  assign instr_pc = bypass ? req_pc : !empty ? head_pc : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      state <= (state == REQ ? imem_gnt : state != IDLE && !imem_rvalid) ? KILL : REQ;
    end else begin
      case (state)
        IDLE: if (space) state <= REQ;
        REQ:
          if (imem_gnt) begin
            state <= WAIT;
            req_pc <= fetch_pc;
            fetch_pc <= fetch_pc + PC_STEP;
          end
        WAIT: if (imem_rvalid) state <= space_after ? REQ : IDLE;
        KILL: if (imem_rvalid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .pc_in(req_pc),
    .instr_in(imem_rdata),
    .count(count),
    .empty(empty),
    .head_pc(head_pc),
    .head_instr(head_instr)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios for fetch_stage in its default (non-bypass) build
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    imem_gnt = 0;
    imem_rvalid = 0;
    imem_rdata = 0;
    instr_ready = 0;
    redirect = 0;
    redirect_pc = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    clear_inputs();
    #2;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_imem: got req=%b addr=%h expected req=0 addr=00000000", imem_req, imem_addr);
    end
    n_tests++;
    if ({instr_valid, instr, instr_pc} !== {1'b0, 32'h13, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_instr: got v=%b instr=%h pc=%h expected v=0 instr=00000013 pc=00000000", instr_valid, instr, instr_pc);
    end
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got req=%b expected 0", imem_req);
    end
  endtask
  task automatic test_sequential();
    do_reset();
    instr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_gnt = 1;
      imem_rvalid = 0;
      #1;
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
        n_fail++;
        $display("FAIL seq_req%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i));
      end
      if (i > 0) begin
        n_tests++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * (i - 1)), 32'hA000_0000 | 32'(4 * (i - 1))}) begin
          n_fail++;
          $display("FAIL seq_out%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, instr_valid, instr_pc, instr, 32'(4 * (i - 1)));
        end
      end
      tick();
      imem_gnt = 0;
      imem_rvalid = 1;
      imem_rdata = 32'hA000_0000 | 32'(4 * i);
      #1;
      n_tests++;
      if ({imem_req, instr_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL seq_wait%0d: got req=%b v=%b expected req=0 v=0", i, imem_req, instr_valid);
      end
    end
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, 32'h8, 32'hA000_0008, 1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL seq_last: got v=%b pc=%h instr=%h req=%b addr=%h expected v=1 pc=00000008 instr=a0000008 req=1 addr=0000000c",
               instr_valid, instr_pc, instr, imem_req, imem_addr);
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      imem_gnt = 1;
      imem_rvalid = 0;
      #1;
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
        n_fail++;
        $display("FAIL bp_req%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i));
      end
      tick();
      imem_gnt = 0;
      imem_rvalid = 1;
      imem_rdata = 32'hA000_0000 | 32'(4 * i);
    end
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({imem_req, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 32'h0, 32'hA000_0000}) begin
      n_fail++;
      $display("FAIL bp_full: got req=%b v=%b pc=%h instr=%h expected req=0 v=1 pc=00000000 instr=a0000000", imem_req, instr_valid, instr_pc, instr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got req=%b expected 0", k, imem_req);
      end
    end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    #1;
    n_tests++;
    if ({imem_req, instr_pc} !== {1'b0, 32'h4}) begin
      n_fail++;
      $display("FAIL bp_pop: got req=%b pc=%h expected req=0 pc=00000004", imem_req, instr_pc);
    end
    tick();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL bp_refetch: got req=%b addr=%h expected req=1 addr=00000010", imem_req, imem_addr);
    end
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'hA000_0010;
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({imem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL bp_refull: got req=%b v=%b pc=%h expected req=0 v=1 pc=00000004", imem_req, instr_valid, instr_pc);
    end
  endtask
  task automatic test_redirect_wait();
    do_reset();
    instr_ready = 1;
    tick();
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    redirect = 1;
    redirect_pc = 32'h103;
    tick();
    redirect = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL rw_kill: got req=%b addr=%h expected req=0 addr=00000100", imem_req, imem_addr);
    end
    tick();
    imem_rvalid = 1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL rw_restart: got req=%b addr=%h v=%b expected req=1 addr=00000100 v=0", imem_req, imem_addr, instr_valid);
    end
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'hA000_0100;
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h100, 32'hA000_0100}) begin
      n_fail++;
      $display("FAIL rw_first: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=a0000100", instr_valid, instr_pc, instr);
    end
  endtask
  task automatic test_redirect_gnt();
    do_reset();
    instr_ready = 1;
    tick();
    imem_gnt = 1;
    redirect = 1;
    redirect_pc = 32'h200;
    tick();
    imem_gnt = 0;
    redirect = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h200}) begin
      n_fail++;
      $display("FAIL rg_kill: got req=%b addr=%h expected req=0 addr=00000200", imem_req, imem_addr);
    end
    imem_rvalid = 1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h200, 1'b0}) begin
      n_fail++;
      $display("FAIL rg_drop: got req=%b addr=%h v=%b expected req=1 addr=00000200 v=0", imem_req, imem_addr, instr_valid);
    end
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'hA000_0200;
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, 32'h200, 32'hA000_0200, 1'b1, 32'h204}) begin
      n_fail++;
      $display("FAIL rg_first: got v=%b pc=%h instr=%h req=%b addr=%h expected v=1 pc=00000200 instr=a0000200 req=1 addr=00000204",
               instr_valid, instr_pc, instr, imem_req, imem_addr);
    end
  endtask
  task automatic test_redirect_rvalid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      imem_rvalid = 0;
      imem_gnt = 1;
      tick();
      imem_gnt = 0;
      imem_rvalid = 1;
      imem_rdata = 32'hA000_0000 | 32'(4 * i);
    end
    tick();
    imem_rvalid = 0;
    imem_gnt = 1;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr_valid, instr_pc} !== {1'b1, 32'h8, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL rr_two: got req=%b addr=%h v=%b pc=%h expected req=1 addr=00000008 v=1 pc=00000000", imem_req, imem_addr, instr_valid, instr_pc);
    end
    tick();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'hA000_0008;
    instr_ready = 1;
    redirect = 1;
    redirect_pc = 32'h300;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if ({instr_valid, instr, instr_pc} !== {1'b0, 32'h13, 32'h0}) begin
      n_fail++;
      $display("FAIL rr_flush: got v=%b instr=%h pc=%h expected v=0 instr=00000013 pc=00000000", instr_valid, instr, instr_pc);
    end
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL rr_req: got req=%b addr=%h expected req=1 addr=00000300", imem_req, imem_addr);
    end
    tick();
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_empty: got v=%b expected 0", instr_valid);
    end
  endtask
  task automatic test_wrap_and_async_reset();
    do_reset();
    tick();
    redirect = 1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_align: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr);
    end
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_pc: got req=%b addr=%h expected req=0 addr=00000000", imem_req, imem_addr);
    end
    imem_rvalid = 1;
    imem_rdata = 32'hA5A5_A5A5;
    tick();
    imem_rvalid = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5}) begin
      n_fail++;
      $display("FAIL wrap_push: got req=%b addr=%h v=%b pc=%h instr=%h expected req=1 addr=00000000 v=1 pc=fffffffc instr=a5a5a5a5",
               imem_req, imem_addr, instr_valid, instr_pc, instr);
    end
    imem_gnt = 1;
    tick();
    imem_gnt = 0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h4}) begin
      n_fail++;
      $display("FAIL wrap_wait: got req=%b addr=%h expected req=0 addr=00000004", imem_req, imem_addr);
    end
    #2;
    reset = 1;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h13, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b addr=%h v=%b instr=%h pc=%h expected req=0 addr=00000000 v=0 instr=00000013 pc=00000000",
               imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_rvalid();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
